// File: rtl/instruction_fetch_unit.sv
// Word-PC fetch engine: one registered imem read per instruction, result held in ir behind a valid/ready handshake.
// Latency 2 cycles from REQ to ir_valid (3 cycles/instr back-to-back); ir_ready low holds ir and stops fetching.
module instruction_fetch_unit #(
   parameter logic [31:0] RESET_PC   = 32'd0,
   parameter int          IMEM_WORDS = 1024,
   parameter int          CNT_W      = 16
) (
   input  logic             clock,
   input  logic             reset_n,
   input  logic             run,
   output logic             mem_en,
   output logic [31:0]      mem_addr,
   input  logic [31:0]      mem_rdata,
   output logic [31:0]      ir,
   output logic [31:0]      ir_pc,
   output logic [31:0]      ir_pc_plus1,
   output logic             ir_valid,
   input  logic             ir_ready,
   input  logic             redirect_valid,
   input  logic [31:0]      redirect_pc,
   output logic             fetch_fault,
   output logic [CNT_W-1:0] fetch_count
);

   typedef enum logic [2:0] {IDLE, REQ, WAIT, VALID, FAULT} state_t;

   localparam logic [31:0] PC_LIMIT = 32'(IMEM_WORDS);

   state_t      state;
   state_t      state_nxt;
   logic [31:0] pc;
   logic        in_range;
   logic        handshake;
   logic        capture;

   assign in_range    = (pc < PC_LIMIT);
   assign handshake   = (state == VALID) && ir_ready;
   // A redirect during WAIT cancels the read, so its data is dropped here.
   assign capture     = (state == WAIT) && !redirect_valid;

   assign mem_en      = (state == REQ) && in_range;
   assign mem_addr    = {pc[29:0], 2'b00};
   assign ir_valid    = (state == VALID);
   assign fetch_fault = (state == FAULT);
   assign ir_pc_plus1 = ir_pc + 32'd1;

   always_comb begin
      state_nxt = state;
      unique case (state)
         IDLE:    if (run) state_nxt = REQ;
         REQ:     state_nxt = in_range ? WAIT : FAULT;
         WAIT:    state_nxt = VALID;
         VALID:   if (handshake) state_nxt = run ? REQ : IDLE;
         FAULT:   state_nxt = FAULT;
         default: state_nxt = IDLE;
      endcase
      if (redirect_valid) state_nxt = run ? REQ : IDLE;
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state       <= IDLE;
         pc          <= RESET_PC;
         ir          <= 32'd0;
         ir_pc       <= 32'd0;
         fetch_count <= '0;
      end else begin
         state <= state_nxt;
         if (redirect_valid)
            pc <= redirect_pc;
         else if (handshake)
            pc <= pc + 32'd1;
         if (handshake)
            fetch_count <= fetch_count + CNT_W'(1);
         if (capture) begin
            ir    <= mem_rdata;
            ir_pc <= pc;
         end
      end
   end

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Bench for instruction_fetch_unit: transaction-level model compared every cycle, plus directed literal checks.
// A registered-read memory returns 0xA0000000+word for every word.
module tb_instruction_fetch_unit;

   localparam int WORDS = 1024;

   logic        clock = 1'b0;
   logic        reset_n = 1'b0;
   logic        run = 1'b0;
   logic        mem_en;
   logic [31:0] mem_addr;
   logic [31:0] mem_rdata = 32'd0;
   logic [31:0] ir;
   logic [31:0] ir_pc;
   logic [31:0] ir_pc_plus1;
   logic        ir_valid;
   logic        ir_ready = 1'b0;
   logic        redirect_valid = 1'b0;
   logic [31:0] redirect_pc = 32'd0;
   logic        fetch_fault;
   logic [15:0] fetch_count;

   int n_cmp = 0;
   int n_bad = 0;

   logic [31:0] mem [0:WORDS-1];
   logic [31:0] addr_q[$];
   logic [31:0] acc_q[$];

   instruction_fetch_unit #(.RESET_PC(32'd0), .IMEM_WORDS(WORDS), .CNT_W(16)) dut (
      .clock(clock), .reset_n(reset_n), .run(run),
      .mem_en(mem_en), .mem_addr(mem_addr), .mem_rdata(mem_rdata),
      .ir(ir), .ir_pc(ir_pc), .ir_pc_plus1(ir_pc_plus1),
      .ir_valid(ir_valid), .ir_ready(ir_ready),
      .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
      .fetch_fault(fetch_fault), .fetch_count(fetch_count)
   );

   always #5 clock = ~clock;

   always @(posedge clock)
      if (mem_en) mem_rdata <= mem[mem_addr[11:2]];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [31:0] qat(input int i);
      return (i < addr_q.size()) ? addr_q[i] : 32'hDEAD_BEEF;
   endfunction

   function automatic logic [31:0] aat(input int i);
      return (i < acc_q.size()) ? acc_q[i] : 32'hDEAD_BEEF;
   endfunction

   // Model: m_lat counts down through "request pending" (2) and "data in flight" (1).
   logic [31:0] m_pc = 32'd0, m_ir = 32'd0, m_ir_pc = 32'd0;
   logic        m_valid = 1'b0, m_fault = 1'b0, m_hs;
   int          m_lat = 0;
   logic [15:0] m_count = 16'd0;

   always @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         m_pc = 32'd0; m_ir = 32'd0; m_ir_pc = 32'd0;
         m_valid = 1'b0; m_fault = 1'b0; m_lat = 0; m_count = 16'd0;
      end else begin
         m_hs = m_valid && ir_ready;
         if (m_hs) m_count++;
         if (redirect_valid) begin
            m_pc = redirect_pc; m_fault = 1'b0; m_valid = 1'b0; m_lat = run ? 2 : 0;
         end else if (m_fault) begin
         end else if (m_valid) begin
            if (m_hs) begin m_valid = 1'b0; m_pc++; m_lat = run ? 2 : 0; end
         end else if (m_lat == 2) begin
            if (m_pc >= 32'(WORDS)) begin m_fault = 1'b1; m_lat = 0; end
            else m_lat = 1;
         end else if (m_lat == 1) begin
            m_ir = mem[m_pc[9:0]]; m_ir_pc = m_pc; m_valid = 1'b1; m_lat = 0;
         end else if (run) begin
            m_lat = 2;
         end
      end
   end

   always @(negedge clock) begin
      check("mem_en", mem_en, (m_lat == 2) && (m_pc < 32'(WORDS)));
      check("mem_addr", mem_addr, {m_pc[29:0], 2'b00});
      check("ir", ir, m_ir);
      check("ir_pc", ir_pc, m_ir_pc);
      check("ir_pc_plus1", ir_pc_plus1, m_ir_pc + 32'd1);
      check("ir_valid", ir_valid, m_valid);
      check("fetch_fault", fetch_fault, m_fault);
      check("fetch_count", fetch_count, m_count);
      if (mem_en) addr_q.push_back(mem_addr);
      if (ir_valid && ir_ready) acc_q.push_back(ir);
   end

   task automatic step(input int n);
      repeat (n) @(posedge clock);
      #1;
   endtask

   initial begin
      int n;
      int first;
      for (int i = 0; i < WORDS; i++) mem[i] = 32'hA000_0000 + 32'(i);

      #1;
      check("rst_ir_valid", ir_valid, 0);
      check("rst_mem_en", mem_en, 0);
      check("rst_count", fetch_count, 0);
      check("rst_fault", fetch_fault, 0);
      step(2);
      reset_n = 1'b1;

      // Sequential fetch of words 0..3
      addr_q.delete(); acc_q.delete();
      run = 1'b1; ir_ready = 1'b1;
      n = 0; first = 0;
      while (!(ir_valid && ir_pc == 32'd3) && n < 40) begin
         step(1); n++;
         if (ir_valid && first == 0) first = n;
      end
      run = 1'b0;
      check("seq_first_valid_edges", first, 3);
      check("seq_fourth_valid_edges", n, 12);
      step(2);
      check("seq_count", fetch_count, 4);
      check("seq_addr_n", addr_q.size(), 4);
      for (int i = 0; i < 4; i++) begin
         check("seq_addr", qat(i), 32'(4 * i));
         check("seq_ir", aat(i), 32'hA000_0000 + 32'(i));
      end

      // Backpressure in VALID
      ir_ready = 1'b0; run = 1'b1;
      n = 0;
      while (!ir_valid && n < 20) begin step(1); n++; end
      check("bp_valid", ir_valid, 1);
      check("bp_ir_pc", ir_pc, 4);
      addr_q.delete();
      repeat (10) begin
         step(1);
         check("bp_hold_ir", ir, 32'hA000_0004);
         check("bp_hold_pc", ir_pc, 4);
         check("bp_hold_valid", ir_valid, 1);
      end
      check("bp_no_reads", addr_q.size(), 0);
      ir_ready = 1'b1;
      n = 0;
      while (addr_q.size() == 0 && n < 20) begin step(1); n++; end
      check("bp_next_addr", qat(0), 32'd20);

      // Redirect while the read of word 5 is in flight
      redirect_valid = 1'b1; redirect_pc = 32'd12;
      addr_q.delete(); acc_q.delete();
      step(1);
      redirect_valid = 1'b0;
      n = 0;
      while (!ir_valid && n < 20) begin step(1); n++; end
      check("rw_ir_pc", ir_pc, 12);
      check("rw_ir_pc_plus1", ir_pc_plus1, 13);
      check("rw_ir", ir, 32'hA000_000C);
      check("rw_addr", qat(0), 32'd48);
      check("rw_reads", addr_q.size(), 1);

      // Redirect in the same cycle as the handshake of ir_pc=13
      n = 0;
      while (!(ir_valid && ir_pc == 32'd13) && n < 20) begin step(1); n++; end
      check("rh_ir_pc", ir_pc, 13);
      redirect_valid = 1'b1; redirect_pc = 32'd7;
      addr_q.delete();
      step(1);
      redirect_valid = 1'b0;
      check("rh_count", fetch_count, 7);
      n = 0;
      while (addr_q.size() == 0 && n < 20) begin step(1); n++; end
      check("rh_next_addr", qat(0), 32'd28);

      // Fetch the last word, then step past the end of memory
      redirect_valid = 1'b1; redirect_pc = 32'd1023;
      step(1);
      redirect_valid = 1'b0;
      addr_q.delete();
      n = 0;
      while (!fetch_fault && n < 20) begin step(1); n++; end
      check("flt_fault", fetch_fault, 1);
      check("flt_count", fetch_count, 8);
      check("flt_ir_pc", ir_pc, 1023);
      check("flt_reads", addr_q.size(), 1);
      check("flt_addr", qat(0), 32'd4092);
      step(4);
      check("flt_sticky", fetch_fault, 1);
      check("flt_no_reads", addr_q.size(), 1);
      redirect_valid = 1'b1; redirect_pc = 32'd0;
      addr_q.delete();
      step(1);
      redirect_valid = 1'b0;
      check("flt_cleared", fetch_fault, 0);
      n = 0;
      while (addr_q.size() == 0 && n < 20) begin step(1); n++; end
      check("flt_restart_addr", qat(0), 32'd0);

      // Asynchronous reset between edges while in WAIT
      #2 reset_n = 1'b0;
      #1;
      check("ar_ir_valid", ir_valid, 0);
      check("ar_mem_en", mem_en, 0);
      check("ar_ir", ir, 0);
      check("ar_ir_pc", ir_pc, 0);
      check("ar_count", fetch_count, 0);
      check("ar_fault", fetch_fault, 0);
      check("ar_mem_addr", mem_addr, 0);
      step(2);
      reset_n = 1'b1;
      addr_q.delete();
      n = 0;
      while (addr_q.size() == 0 && n < 20) begin step(1); n++; end
      check("ar_restart_edges", n, 2);
      check("ar_restart_addr", qat(0), 32'd0);
      step(3);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      #50000;
      $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
      $fatal(1, "watchdog expired");
   end

endmodule

// File: doc/instruction_fetch_unit.md
Name: instruction_fetch_unit

Overview:
- Fetch-side initiator for the multi-cycle processor's word-organised synchronous instruction memory (en, 32-bit address, 1-cycle registered read).
- Holds the word PC and issues one read per instruction.
- Captures the returned word into an instruction register and presents it to the control/decode stage over a valid/ready handshake.
- Accepts PC redirects from branch/jump/call/JR execution.

Parameters:
- RESET_PC, 32'd0, word PC loaded on reset.
- IMEM_WORDS, 1024, instruction memory depth in words; PC >= IMEM_WORDS is a fetch fault.
- CNT_W, 16, width of the retired-fetch counter.

Ports:
- clock  in  1  system clock, rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- run  in  1  fetch enable from control unit.
- mem_en  out  1  memory read enable.
- mem_addr  out  32  byte address = {pc[29:0],2'b00}.
- mem_rdata  in  32  memory instruction output, valid the cycle after mem_en.
- ir  out  32  captured instruction.
- ir_pc  out  32  word PC of ir.
- ir_pc_plus1  out  32  ir_pc+1 (CALL return address).
- ir_valid  out  1  ir holds an unconsumed instruction.
- ir_ready  in  1  consumer accepts ir this cycle.
- redirect_valid  in  1  load new PC.
- redirect_pc  in  32  target word PC.
- fetch_fault  out  1  PC out of range; sticky.
- fetch_count  out  CNT_W  instructions accepted (wraps).

Behaviour:
- Reset is asynchronous and active-low.
  - State=IDLE, pc=RESET_PC, ir=0, ir_pc=0, ir_valid=0, mem_en=0, fetch_fault=0, fetch_count=0.
  - Reset mid-fetch discards everything; no memory read is issued on the first edge after release.
- mem_en=1 only in REQ; mem_addr is always driven from pc. Outputs are state-decoded or registered; mem_rdata→ir has no combinational path.
- States:
  - IDLE: run=1 → REQ.
  - REQ: one cycle, mem_en=1. If pc >= IMEM_WORDS, mem_en=0 and go to FAULT instead. Otherwise → WAIT.
  - WAIT: mem_rdata valid. At the closing edge: ir<=mem_rdata, ir_pc<=pc, ir_valid<=1 → VALID.
  - VALID: hold ir/ir_valid until ir_valid&ir_ready. On handshake:
    - pc<=pc+1 (32-bit wrap);
    - fetch_count+=1;
    - ir_valid<=0;
    - next state REQ if run=1, else IDLE.
  - FAULT: fetch_fault=1, no reads. Leaves only on redirect_valid or reset.
- Latency: first edge in REQ to ir_valid high = 2 cycles. Back-to-back throughput is 1 instruction per 3 cycles when ir_ready is held high.
- Redirect has priority over all other transitions and is accepted in every state:
  - pc<=redirect_pc; fetch_fault<=0.
  - ir_valid<=0, except when handshaking in the same cycle (the handshake completes).
  - Next state: REQ if run=1, else IDLE.
  - In REQ or WAIT: the in-flight read is cancelled; the returning mem_rdata is not captured.
  - With a VALID handshake in the same cycle: fetch_count increments; next pc = redirect_pc, not pc+1.
- run=0 while in REQ/WAIT: the fetch completes to VALID; the FSM stops only after the handshake.
- ir_pc_plus1 = ir_pc+1, combinational from ir_pc.
- ir_ready while ir_valid=0 is ignored.

Test Plan:
- Sequential fetch. Mem words 0..3 = 0xA0000000+i; release reset; run=1; ir_ready=1.
  - mem_addr sequence is 0,4,8,12.
  - ir sequence is 0xA0000000..0xA0000003.
  - ir_valid first rises 3 edges after run is seen in IDLE; thereafter one instruction every 3 cycles.
  - fetch_count=4.
- Backpressure. ir_ready=0 for 10 cycles in VALID.
  - ir, ir_pc and ir_valid are stable.
  - mem_en=0 throughout.
  - After ir_ready=1, the next mem_addr is ir_pc*4+4.
- Redirect in WAIT. pc=5, redirect_pc=12.
  - The word at 5 is never captured.
  - The next mem_addr is 48; ir_pc=12; ir_pc_plus1=13.
- Redirect concurrent with handshake. ir_pc=13 handshaking, redirect_pc=7 in the same cycle.
  - fetch_count increments.
  - The next fetch address is 28, not 56.
- Fault. RESET_PC=1023; fetch then handshake.
  - pc=1024 → FAULT, fetch_fault=1, mem_en never asserted.
  - redirect_pc=0 clears the fault and fetches from address 0.
- Async reset. Assert reset_n=0 mid-WAIT, between edges.
  - All outputs clear immediately.
  - After release with run=1, the fetch restarts at RESET_PC.
